img_pix_source: RTL and testbench
=================================

// Module: img_pix_source
// PURPOSE
//   Fabric-side pixel producer for the img_cpu_reader handshake. It answers each
//   get_next_pix request from the HPS-side reader with one 24-bit RGB pixel fetched
//   from an on-chip frame buffer, and raises pix_rdy while that pixel is valid.
//   After the last pixel of the frame it asserts img_done. It sits between the frame
//   buffer read port and the cpu system's img_cpu_reader_0 conduits.
// PARAMETERS
//   IMG_W      320  pixels per line
//   IMG_H      240  lines per frame; NUM_PIX = IMG_W*IMG_H
//   ADDR_W     17   frame-buffer address width; NUM_PIX <= 2**ADDR_W
//   BASE_ADDR  0    frame-buffer address of pixel 0
//   RD_LAT     2    frame-buffer read latency in cycles (>=1)
// PORTS
//   clk_clk       in   1       system clock; all logic on rising edge
//   reset_reset   in   1       asynchronous, active-high reset
//   start         in   1       1-cycle pulse: begin streaming a frame
//   cpu_rdy       in   1       reader present/enabled; low aborts a frame
//   get_next_pix  in   1       reader request (4-phase level handshake)
//   pix_rdy       out  1       pixel_data valid, held until request released
//   pixel_data    out  24      RGB 8:8:8 pixel, stable while pix_rdy=1
//   img_done      out  1       whole frame delivered (level)
//   mem_rd_en     out  1       frame-buffer read strobe, 1 cycle per pixel
//   mem_addr      out  ADDR_W  frame-buffer read address
//   mem_rd_data   in   24      frame-buffer data, valid RD_LAT cycles after mem_rd_en
//   busy          out  1       state not IDLE and not DONE
//   pix_count     out  ADDR_W  pixels completed in the current frame
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, pixel counter 0, req_q (previous
//     get_next_pix sample) 0.
//   States: IDLE, WAIT_REQ, FETCH, LAT, HOLD, DONE.
//   IDLE: start&&cpu_rdy -> WAIT_REQ, counter 0. start with cpu_rdy=0 is ignored.
//   WAIT_REQ: rising edge (get_next_pix=1 && req_q=0) detected in cycle E -> FETCH.
//     A request that is already high on entry is served only after it goes low,
//     then high again.
//   FETCH (cycle E+1): mem_rd_en=1, mem_addr=BASE_ADDR+counter -> LAT.
//   LAT: wait RD_LAT cycles. At E+1+RD_LAT, capture mem_rd_data into pixel_data
//     and move to HOLD. pix_rdy=1 from E+RD_LAT+2 (E+4 for the default).
//   HOLD: pix_rdy=1 and pixel_data frozen. When get_next_pix is sampled 0, pix_rdy=0
//     on the next cycle, counter+1. If the new count == NUM_PIX -> DONE, else WAIT_REQ.
//   DONE: img_done=1, pix_rdy=0. start&&cpu_rdy -> WAIT_REQ, counter 0, img_done=0
//     next cycle. cpu_rdy=0 -> IDLE, img_done=0.
//   Abort: cpu_rdy=0 in WAIT_REQ/FETCH/LAT/HOLD -> IDLE next cycle. pix_rdy=0,
//     counter 0, in-flight read data discarded.
//   start in WAIT_REQ/FETCH/LAT/HOLD is ignored.
//   Exactly one mem_rd_en per pixel. mem_addr holds its last value when idle.
//   pixel_data keeps its last value after the handshake completes.
//   Counter width is ADDR_W; the compare uses NUM_PIX-1 before increment, so there
//     is no wrap.
//   pix_count = counter. busy is combinational from state.
// TESTING
//   1 Reset asserted mid-HOLD -> pix_rdy, img_done, mem_rd_en, busy, pix_count all
//     0 immediately.
//   2 IMG_W=4, IMG_H=2, RD_LAT=2, memory model returns 0xA00000+addr; start, then
//     request rise at E -> mem_rd_en at E+1 addr 0, pix_rdy at E+4, data 0xA00000.
//   3 Serve 8 full handshakes -> addresses 0..7 in order, data 0xA00000..0xA00007,
//     img_done=1 the cycle after the 8th pix_rdy fall, pix_count=8.
//   4 Drop cpu_rdy during HOLD of pixel 3 -> IDLE, pix_rdy=0 next cycle;
//     restart reads addr 0.
//   5 Reader holds get_next_pix high for 50 cycles -> pixel_data stable, exactly
//     one mem_rd_en, no second pixel.
//   6 start while busy ignored; start with cpu_rdy=0 ignored; start in DONE ->
//     img_done=0, next read at addr 0.

Source files
------------

// File: rtl/img_pix_source.sv
// Fabric-side pixel producer: serves one frame-buffer pixel per get_next_pix
// request over a 4-phase level handshake and flags img_done after the last pixel.
module img_pix_source #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int ADDR_W    = 17,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              cpu_rdy,
  input  logic              get_next_pix,
  output logic              pix_rdy,
  output logic [23:0]       pixel_data,
  output logic              img_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] pix_count
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_REQ, FETCH, LAT, HOLD, DONE} state_t;

  state_t             state;
  logic               req_q;
  logic [ADDR_W-1:0]  count;
  logic [LAT_W-1:0]   lat_cnt;
  logic               in_frame;

  assign in_frame = (state == WAIT_REQ) || (state == FETCH) ||
                    (state == LAT) || (state == HOLD);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      count      <= '0;
      lat_cnt    <= '0;
      pix_rdy    <= 1'b0;
      pixel_data <= '0;
      img_done   <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
    end else begin
      req_q     <= get_next_pix;
      mem_rd_en <= 1'b0;
      // Losing the reader mid-frame wins over any handshake progress.
      if (in_frame && !cpu_rdy) begin
        state   <= IDLE;
        pix_rdy <= 1'b0;
        count   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && cpu_rdy) begin
              state <= WAIT_REQ;
              count <= '0;
            end
          end
          WAIT_REQ: begin
            if (get_next_pix && !req_q) begin
              state     <= FETCH;
              mem_rd_en <= 1'b1;
              mem_addr  <= ADDR_W'(BASE_ADDR) + count;
            end
          end
          FETCH: begin
            state   <= LAT;
            lat_cnt <= '0;
          end
          LAT: begin
            if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
              pixel_data <= mem_rd_data;
              pix_rdy    <= 1'b1;
              state      <= HOLD;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (!get_next_pix) begin
              pix_rdy <= 1'b0;
              count   <= count + 1'b1;
              if (count == ADDR_W'(NUM_PIX - 1)) begin
                state    <= DONE;
                img_done <= 1'b1;
              end else begin
                state <= WAIT_REQ;
              end
            end
          end
          DONE: begin
            if (start && cpu_rdy) begin
              state    <= WAIT_REQ;
              count    <= '0;
              img_done <= 1'b0;
            end else if (!cpu_rdy) begin
              state    <= IDLE;
              img_done <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy = (state != IDLE) && (state != DONE);
  end

  assign pix_count = count;

endmodule

// File: tb/tb_img_pix_source.sv
// Bench for img_pix_source on a 4x2 frame with a 2-cycle frame-buffer model
// returning 0xA00000+addr only in the cycle the read data is due.
module tb_img_pix_source;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, cpu_rdy = 1'b0, g = 1'b0;
  logic          pix_rdy, img_done, mem_rd_en, busy;
  logic [23:0]   pixel_data, mem_rd_data;
  logic [AW-1:0] mem_addr, pix_count;

  logic [23:0]   d1 = 24'h5A5A5A, d2 = 24'h5A5A5A;
  logic [AW-1:0] rd_addrs[$];
  int            exp_q[$];
  int            n_chk = 0, n_fail = 0;

  img_pix_source #(.IMG_W(4), .IMG_H(2), .ADDR_W(AW), .BASE_ADDR(0), .RD_LAT(2)) dut (
    .clk_clk(clk), .reset_reset(rst), .start(start), .cpu_rdy(cpu_rdy),
    .get_next_pix(g), .pix_rdy(pix_rdy), .pixel_data(pixel_data),
    .img_done(img_done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .busy(busy), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= mem_rd_en ? (24'hA00000 + 24'(mem_addr)) : 24'h5A5A5A;
    d2 <= d1;
  end
  assign mem_rd_data = d2;

  always @(negedge clk) if (mem_rd_en) rd_addrs.push_back(mem_addr);

  typedef struct {
    logic          s, c, r;
    logic          e_rdy, e_done, e_busy, e_rd;
    logic [AW-1:0] e_addr, e_cnt;
    logic [23:0]   e_data;
  } vec_t;

  function automatic vec_t mk(logic s, logic c, logic r, logic e_rdy, logic e_done,
                              logic e_busy, logic e_rd, int e_addr, int e_cnt, int e_data);
    vec_t v;
    v.s = s; v.c = c; v.r = r;
    v.e_rdy = e_rdy; v.e_done = e_done; v.e_busy = e_busy; v.e_rd = e_rd;
    v.e_addr = AW'(e_addr); v.e_cnt = AW'(e_cnt); v.e_data = 24'(e_data);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic req_and_check(input int idx);
    int k;
    int e;
    logic [AW-1:0] a;
    exp_q.push_back(idx);
    g = 1'b1;
    k = 0;
    while (!pix_rdy && k < 20) begin tick(); k++; end
    chk("pix_rdy_rise", 64'(pix_rdy), 64'd1);
    e = exp_q.pop_front();
    chk("pixel_data", 64'(pixel_data), 64'(24'hA00000 + e));
    if (rd_addrs.size() == 1) a = rd_addrs.pop_front();
    else begin a = '1; rd_addrs.delete(); end
    chk("rd_addr", 64'(a), 64'(e));
  endtask

  task automatic release_req();
    int k;
    g = 1'b0;
    k = 0;
    while (pix_rdy && k < 20) begin tick(); k++; end
    chk("pix_rdy_fall", 64'(pix_rdy), 64'd0);
  endtask

  task automatic serve(input int idx, input int hold);
    req_and_check(idx);
    repeat (hold) tick();
    chk("hold_data", 64'(pixel_data), 64'(24'hA00000 + idx));
    release_req();
  endtask

  vec_t vecs[9];

  initial begin
    // inputs, then expected rdy/done/busy/rd_en/addr/count/data after the edge
    vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[2] = mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    vecs[3] = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    vecs[4] = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    vecs[5] = mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 24'hA00000);
    vecs[6] = mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 24'hA00000);
    vecs[7] = mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 24'hA00000);
    vecs[8] = mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 24'hA00000);

    tick(); tick();
    chk("reset_state", {pix_rdy, img_done, mem_rd_en, busy, pix_count, pixel_data},
        {4'b0, AW'(0), 24'h0});
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      start = vecs[i].s; cpu_rdy = vecs[i].c; g = vecs[i].r;
      tick();
      chk($sformatf("vec%0d", i),
          {pix_rdy, img_done, busy, mem_rd_en, mem_addr, pix_count, pixel_data},
          {vecs[i].e_rdy, vecs[i].e_done, vecs[i].e_busy, vecs[i].e_rd,
           vecs[i].e_addr, vecs[i].e_cnt, vecs[i].e_data});
    end
    start = 1'b0;
    rd_addrs.delete();

    for (int p = 1; p < 8; p++) serve(p, 2);
    chk("done_level", 64'(img_done), 64'd1);
    chk("done_count", 64'(pix_count), 64'd8);
    chk("done_busy", 64'(busy), 64'd0);
    tick(); tick();
    chk("done_no_read", 64'(rd_addrs.size()), 64'd0);

    start = 1'b1; tick(); start = 1'b0;
    chk("restart_from_done", {img_done, busy, pix_count}, {1'b0, 1'b1, AW'(0)});
    serve(0, 2);

    req_and_check(1);
    repeat (50) tick();
    chk("long_hold", {pix_rdy, pixel_data}, {1'b1, 24'hA00001});
    chk("long_hold_reads", 64'(rd_addrs.size()), 64'd0);
    release_req();

    start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_while_busy", {busy, pix_count}, {1'b1, AW'(2)});
    serve(2, 1);

    req_and_check(3);
    cpu_rdy = 1'b0; tick();
    chk("abort", {pix_rdy, busy, pix_count}, {1'b0, 1'b0, AW'(0)});
    cpu_rdy = 1'b1; g = 1'b0; tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    serve(0, 1);

    release_req();
    req_and_check(1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {pix_rdy, img_done, mem_rd_en, busy, pix_count},
        {4'b0, AW'(0)});
    tick(); rst = 1'b0; g = 1'b1; rd_addrs.delete();

    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("req_high_on_entry", {pix_rdy, 32'(rd_addrs.size())}, {1'b0, 32'd0});
    g = 1'b0; tick();
    serve(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
